stage_ex: RTL
=============

Name: stage_ex

Overview:
- Execute stage plus EX/MA pipeline register; directly upstream of the memory-access stage, which consumes every output of this block.
- Resolves operand forwarding and runs the single-cycle ALU.
- Runs an iterative 32-cycle multiply/divide unit, asserting a stall request upstream while it iterates.

Parameters:
WIDTH, 32, datapath width (all logic below assumes 32; iteration count = WIDTH)
EXMA_WIDTH, 111, EX/MA register width = 3+2+32+32+5+32+5

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
i_ex_WB  in  3  write-back control from ID/EX
i_ex_MA  in  2  memory-access control from ID/EX
i_ex_op  in  5  ALU op code
i_ex_ALUsrc  in  1  1 = operand B is i_ex_imm
i_ex_Rs1_val  in  32  register-file value of rs1
i_ex_Rs2_val  in  32  register-file value of rs2
i_ex_imm  in  32  sign-extended immediate
i_ex_Rs2_addr  in  5  rs2 address
i_ex_PC  in  32  program counter
i_ex_Rdst  in  5  destination register
i_ex_fwdA  in  2  forward select for rs1: 00 reg, 01 EX/MA, 10 MA/WB, 11 reg
i_ex_fwdB  in  2  forward select for rs2, same encoding
i_ex_fwd_ma  in  32  ALU result currently in EX/MA
i_ex_fwd_wb  in  32  write-back mux value
i_ex_flush  in  1  clear EX/MA, abort multi-cycle op
i_ex_stall  in  1  hold EX/MA
o_ex_WB  out  3  registered
o_ex_MA  out  2  registered
o_ex_ALU_rslt  out  32  registered result
o_ex_Rs2_val  out  32  registered forwarded rs2 (store data)
o_ex_Rs2_addr  out  5  registered
o_ex_PC  out  32  registered
o_ex_Rdst  out  5  registered
o_ex_busy  out  1  combinational stall request to hazard unit

Behaviour:
- Reset (rst=1 at edge): all EX/MA fields 0, FSM→IDLE, counter 0. o_ex_busy forced 0 while rst=1.
- Operand A = fwdA-selected value.
- Forwarded B (fB) = fwdB-selected value.
- Operand B = i_ex_imm if i_ex_ALUsrc=1, else fB. o_ex_Rs2_val captures fB, never imm.
- Single-cycle ops, all mod 2^32, no flags:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount B[4:0])
  - 8 SLT signed → 0/1; 9 SLTU → 0/1
  - 10 PASSB
  - 11–15 and 20–31 → result 0
- Single-cycle latency: result appears at the EX/MA outputs on the next edge.
- Multi-cycle ops: 16 MUL (low word), 17 MULHU (high word, unsigned), 18 DIVU, 19 REMU.
- FSM states:
  - IDLE: multi-cycle op present → busy=1; latch A and B; cnt=0; go RUN.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle; busy=1; when cnt=31 go DONE, else cnt++.
  - DONE: busy=0; result mux selects unit result; EX/MA captures it. If i_ex_stall=0 go IDLE, else stay in DONE and hold.
- Multi-cycle timing: op presented in cycle 0 → captured at end of cycle 33; o_ex_busy high for cycles 0–32.
- While busy=1, EX/MA loads a bubble (all fields 0) unless stalled. Upstream holds ID/EX, so operands stay stable.
- Forwarded values are sampled only in the IDLE accept cycle.
- DIVU by 0: quotient 0xFFFFFFFF. REMU by 0: remainder = dividend. No exception.
- Priority: rst > i_ex_flush > i_ex_stall > normal load.
  - Flush: EX/MA → 0, FSM → IDLE, busy=0 the cycle after. A flushed op is never re-run unless re-presented.
  - Stall: EX/MA holds. FSM continues RUN iterations but waits in DONE.

Test Plan:
- ADD, fwdA=01, i_ex_fwd_ma=0x10, Rs2_val=0x5, ALUsrc=0 → next edge o_ex_ALU_rslt=0x15; WB, MA, PC, Rdst passed through.
- SUB 0x0 − 0x1 → 0xFFFFFFFF. SRA 0x80000000 by 4 → 0xF8000000. SLT(−1,1)=1, SLTU(−1,1)=0.
- MUL 0xFFFFFFFF×2 → 0xFFFFFFFE; MULHU same operands → 0x1. busy high exactly 33 cycles, two bubbles minimum observed, result captured at edge 34.
- DIVU 100/7 → 14; REMU → 2. DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- Flush asserted in RUN cycle 10 → next edge EX/MA all 0, busy=0. Re-present MUL 3×4 → 12 after full 34-cycle latency.
- i_ex_stall=1 for 3 cycles while DONE → outputs hold, FSM stays DONE; release → result captured, FSM IDLE. Store op: ALUsrc=1, fwdB=10 → o_ex_Rs2_val = i_ex_fwd_wb.

Source files
------------

// File: rtl/stage_ex.sv
// -----------------------------------------------------------------------------
// stage_ex -- execute stage plus EX/MA pipeline register.
//
// Resolves operand forwarding, runs the single-cycle ALU and an iterative
// 32-step multiply/divide unit, and registers everything the memory-access
// stage needs into one packed EX/MA register.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   i_ex_WB/MA      write-back / memory-access control from ID/EX
//   i_ex_op         operation code (0..10 single-cycle, 16..19 multi-cycle)
//   i_ex_ALUsrc     1 = operand B is the immediate
//   i_ex_Rs1_val    rs1 register-file value
//   i_ex_Rs2_val    rs2 register-file value
//   i_ex_imm        sign-extended immediate
//   i_ex_Rs2_addr   rs2 address (passed through)
//   i_ex_PC         program counter (passed through)
//   i_ex_Rdst       destination register (passed through)
//   i_ex_fwdA/B     forward selects: 00/11 register, 01 EX/MA, 10 MA/WB
//   i_ex_fwd_ma     ALU result currently in EX/MA
//   i_ex_fwd_wb     write-back mux value
//   i_ex_flush      clear EX/MA and abort any multi-cycle operation
//   i_ex_stall      hold EX/MA
//   o_ex_*          registered EX/MA fields
//   o_ex_busy       combinational stall request while the mul/div iterates
//
// Handshake: o_ex_busy is a request, not a valid/ready pair. While it is high
// the upstream stages hold ID/EX, so the operation and its operands stay
// stable; EX/MA receives bubbles. The multi-cycle result is written in the
// first cycle busy is low (DONE), and only when i_ex_stall is low.
// -----------------------------------------------------------------------------
module stage_ex #(
    parameter int WIDTH      = 32,
    parameter int EXMA_WIDTH = 111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       i_ex_WB,
    input  logic [1:0]       i_ex_MA,
    input  logic [4:0]       i_ex_op,
    input  logic             i_ex_ALUsrc,
    input  logic [WIDTH-1:0] i_ex_Rs1_val,
    input  logic [WIDTH-1:0] i_ex_Rs2_val,
    input  logic [WIDTH-1:0] i_ex_imm,
    input  logic [4:0]       i_ex_Rs2_addr,
    input  logic [WIDTH-1:0] i_ex_PC,
    input  logic [4:0]       i_ex_Rdst,
    input  logic [1:0]       i_ex_fwdA,
    input  logic [1:0]       i_ex_fwdB,
    input  logic [WIDTH-1:0] i_ex_fwd_ma,
    input  logic [WIDTH-1:0] i_ex_fwd_wb,
    input  logic             i_ex_flush,
    input  logic             i_ex_stall,
    output logic [2:0]       o_ex_WB,
    output logic [1:0]       o_ex_MA,
    output logic [WIDTH-1:0] o_ex_ALU_rslt,
    output logic [WIDTH-1:0] o_ex_Rs2_val,
    output logic [4:0]       o_ex_Rs2_addr,
    output logic [WIDTH-1:0] o_ex_PC,
    output logic [4:0]       o_ex_Rdst,
    output logic             o_ex_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    // hi/lo hold {product high, product low} for multiply and
    // {remainder, quotient} for divide; both start as {0, A}.
    logic [WIDTH-1:0]      hi_q, hi_d;
    logic [WIDTH-1:0]      lo_q, lo_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic [WIDTH-1:0]      fb_q, fb_d;
    logic [1:0]            mop_q, mop_d;
    logic [EXMA_WIDTH-1:0] exma_q, exma_d;

    logic [WIDTH-1:0]      op_a, fwd_b, op_b;
    logic [WIDTH-1:0]      alu_rslt, unit_rslt;
    logic                  is_multi;
    logic                  busy_raw;
    logic [WIDTH:0]        mul_sum;
    logic [WIDTH:0]        div_sh;
    logic                  div_borrow;
    logic [WIDTH-1:0]      div_diff;

    // ---------------- operand forwarding ----------------
    always_comb begin
        op_a = i_ex_Rs1_val;
        case (i_ex_fwdA)
            2'b01:   op_a = i_ex_fwd_ma;
            2'b10:   op_a = i_ex_fwd_wb;
            default: op_a = i_ex_Rs1_val;
        endcase
        fwd_b = i_ex_Rs2_val;
        case (i_ex_fwdB)
            2'b01:   fwd_b = i_ex_fwd_ma;
            2'b10:   fwd_b = i_ex_fwd_wb;
            default: fwd_b = i_ex_Rs2_val;
        endcase
        op_b = i_ex_ALUsrc ? i_ex_imm : fwd_b;
    end

    // Ops 16..19 share the prefix 100; op[1] selects divide, op[0] selects
    // the high/remainder half.
    assign is_multi = (i_ex_op[4:2] == 3'b100);

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        alu_rslt = '0;
        case (i_ex_op)
            5'd0:    alu_rslt = op_a + op_b;
            5'd1:    alu_rslt = op_a - op_b;
            5'd2:    alu_rslt = op_a & op_b;
            5'd3:    alu_rslt = op_a | op_b;
            5'd4:    alu_rslt = op_a ^ op_b;
            5'd5:    alu_rslt = op_a << op_b[4:0];
            5'd6:    alu_rslt = op_a >> op_b[4:0];
            5'd7:    alu_rslt = $signed(op_a) >>> op_b[4:0];
            5'd8:    alu_rslt = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            5'd9:    alu_rslt = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            5'd10:   alu_rslt = op_b;
            default: alu_rslt = '0;
        endcase
    end

    // ---------------- mul/div datapath step ----------------
    // Multiply: add B into the high half when the current multiplier bit is
    // set, then shift the whole {carry, hi, lo} right by one.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract B if it fits. The remainder stays below B, so the shifted
    // value minus B always fits in WIDTH bits when no borrow occurs. A zero
    // divisor never borrows, giving an all-ones quotient and remainder = A.
    assign div_sh     = {hi_q, lo_q[WIDTH-1]};
    assign div_borrow = (div_sh < {1'b0, b_q});
    assign div_diff   = div_sh[WIDTH-1:0] - b_q;

    assign unit_rslt = mop_q[0] ? hi_q : lo_q;

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        fb_d     = fb_q;
        mop_d    = mop_q;
        busy_raw = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_multi) begin
                    busy_raw = 1'b1;
                    // Forwarded operands are only valid now; latch them.
                    hi_d     = '0;
                    lo_d     = op_a;
                    b_d      = op_b;
                    fb_d     = fwd_b;
                    mop_d    = i_ex_op[1:0];
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                busy_raw = 1'b1;
                if (mop_q[1]) begin
                    hi_d = div_borrow ? div_sh[WIDTH-1:0] : div_diff;
                    lo_d = {lo_q[WIDTH-2:0], ~div_borrow};
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DONE: begin
                if (!i_ex_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Flush aborts whatever is in flight; the op is only re-run if
        // upstream presents it again.
        if (i_ex_flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    assign o_ex_busy = busy_raw & ~rst;

    // ---------------- EX/MA next value ----------------
    // Layout (msb..lsb): WB, MA, ALU result, Rs2 value, Rs2 addr, PC, Rdst.
    always_comb begin
        exma_d = exma_q;
        if (i_ex_flush) begin
            exma_d = '0;
        end else if (i_ex_stall) begin
            exma_d = exma_q;
        end else if (state_q == S_DONE) begin
            exma_d = {i_ex_WB, i_ex_MA, unit_rslt, fb_q,
                      i_ex_Rs2_addr, i_ex_PC, i_ex_Rdst};
        end else if (busy_raw) begin
            exma_d = '0;
        end else begin
            exma_d = {i_ex_WB, i_ex_MA, alu_rslt, fwd_b,
                      i_ex_Rs2_addr, i_ex_PC, i_ex_Rdst};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            fb_q    <= '0;
            mop_q   <= '0;
            exma_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            fb_q    <= fb_d;
            mop_q   <= mop_d;
            exma_q  <= exma_d;
        end
    end

    assign o_ex_Rdst     = exma_q[4:0];
    assign o_ex_PC       = exma_q[36:5];
    assign o_ex_Rs2_addr = exma_q[41:37];
    assign o_ex_Rs2_val  = exma_q[73:42];
    assign o_ex_ALU_rslt = exma_q[105:74];
    assign o_ex_MA       = exma_q[107:106];
    assign o_ex_WB       = exma_q[110:108];

endmodule
